// File: rtl/string_hw_loader.sv
// Avalon-MM staging slave for the string accelerator. It loads the A/B operands,
// runs the go/done handshake with a timeout, and exposes the result and status words.
module string_hw_loader #(
    parameter int MAX_BLOCKS = 2,
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              address,
    input  logic                           chipselect,
    input  logic                           write,
    input  logic [31:0]                    writedata,
    input  logic                           read,
    output logic [31:0]                    readdata,
    output logic                           go,
    output logic [3:0]                     index,
    output logic [0:4*MAX_BLOCKS-1][7:0]   A,
    output logic [0:4*MAX_BLOCKS-1][7:0]   B,
    input  logic                           done,
    input  logic [0:4*MAX_BLOCKS-1][7:0]   Result
);
    localparam int M     = MAX_BLOCKS;
    localparam int N     = 4 * MAX_BLOCKS;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2 * M);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2 * M + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [0:N-1][7:0]  a_q, a_d;
    logic [0:N-1][7:0]  b_q, b_d;
    logic [0:N-1][7:0]  res_q, res_d;
    logic [3:0]         index_q, index_d;
    logic               done_flag_q, done_flag_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        readdata_q, readdata_d;

    logic [31:0]        a_word   [M];
    logic [31:0]        b_word   [M];
    logic [31:0]        res_word [M];
    logic               busy;
    logic               wr_idle;
    logic               rd_en;

    // Big-endian word views: the lowest-numbered character sits in bits [31:24].
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_word
            assign a_word[gi]   = {a_q[4*gi], a_q[4*gi+1], a_q[4*gi+2], a_q[4*gi+3]};
            assign b_word[gi]   = {b_q[4*gi], b_q[4*gi+1], b_q[4*gi+2], b_q[4*gi+3]};
            assign res_word[gi] = {res_q[4*gi], res_q[4*gi+1], res_q[4*gi+2], res_q[4*gi+3]};
        end
    endgenerate

    assign busy    = (state_q != IDLE);
    assign wr_idle = chipselect && write && !busy;
    assign rd_en   = chipselect && read;

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        index_d        = index_q;
        done_flag_d    = done_flag_q;
        timeout_flag_d = timeout_flag_q;
        cnt_d          = cnt_q;
        readdata_d     = readdata_q;

        if (wr_idle) begin
            for (int k = 0; k < M; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (address == ADDR_W'(k))
                        a_d[4*k+c] = writedata[31-8*c -: 8];
                    if (address == ADDR_W'(M + k))
                        b_d[4*k+c] = writedata[31-8*c -: 8];
                end
            end
            if (address == CTRL_ADDR) begin
                index_d = writedata[4:1];
                if (writedata[0]) begin
                    state_d        = RUN;
                    done_flag_d    = 1'b0;
                    timeout_flag_d = 1'b0;
                    cnt_d          = '0;
                end
            end
        end

        case (state_q)
            RUN: begin
                // done takes priority over an expiring counter on the same edge
                if (done) begin
                    res_d       = Result;
                    done_flag_d = 1'b1;
                    state_d     = DRAIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_flag_d = 1'b1;
                    state_d        = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!done)
                    state_d = IDLE;
            end
            default: ;
        endcase

        if (rd_en) begin
            readdata_d = '0;
            for (int k = 0; k < M; k++) begin
                if (address == ADDR_W'(k))
                    readdata_d = a_word[k];
                if (address == ADDR_W'(M + k))
                    readdata_d = b_word[k];
                if (address == ADDR_W'(2 * M + 2 + k))
                    readdata_d = res_word[k];
            end
            if (address == CTRL_ADDR)
                readdata_d = {27'b0, index_q, 1'b0};
            if (address == STAT_ADDR)
                readdata_d = {29'b0, timeout_flag_q, done_flag_q, busy};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            index_q        <= '0;
            done_flag_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
            cnt_q          <= '0;
            readdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            res_q          <= res_d;
            index_q        <= index_d;
            done_flag_q    <= done_flag_d;
            timeout_flag_q <= timeout_flag_d;
            cnt_q          <= cnt_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign go       = (state_q == RUN);
    assign index    = index_q;
    assign A        = a_q;
    assign B        = b_q;

endmodule

// File: tb/tb_string_hw_loader.sv
// Randomized bench for string_hw_loader: a behavioural accelerator plus a
// register-level model of what software should observe through the slave.
module tb_string_hw_loader;
    localparam int M    = 2;
    localparam int N    = 4 * M;
    localparam int AW   = 4;
    localparam int TO   = 16;
    localparam int CTRL = 2 * M;
    localparam int STAT = 2 * M + 1;
    localparam int RES  = 2 * M + 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [AW-1:0]        address = '0;
    logic                 chipselect = 1'b0;
    logic                 write = 1'b0;
    logic [31:0]          writedata = '0;
    logic                 read = 1'b0;
    logic [31:0]          readdata;
    logic                 go;
    logic [3:0]           index;
    logic [0:N-1][7:0]    A;
    logic [0:N-1][7:0]    B;
    logic                 done = 1'b0;
    logic [0:N-1][7:0]    Result = '0;

    always #5 clk = ~clk;

    string_hw_loader #(.MAX_BLOCKS(M), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .read(read), .readdata(readdata),
        .go(go), .index(index), .A(A), .B(B), .done(done), .Result(Result)
    );

    int total = 0;
    int bad = 0;

    // Software-visible model
    logic [0:N-1][7:0] m_a = '0;
    logic [0:N-1][7:0] m_b = '0;
    logic [31:0]       m_res [M];
    logic [3:0]        m_idx = '0;

    // Accelerator controls and observations
    int  lat = 1;
    int  hold = 0;
    bit  stall = 1'b0;
    int  run_len = 0;
    int  hold_cnt = 0;
    int  last_go_len = 0;
    int  go_rises = 0;
    logic prev_go = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [0:N-1][7:0] acc_op(input logic [3:0] op,
                                                 input logic [0:N-1][7:0] a,
                                                 input logic [0:N-1][7:0] b);
        logic [0:N-1][7:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case (op)
                4'd0: ;
                4'd1: r[i] = (a[i] >= 8'h61 && a[i] <= 8'h7a) ? a[i] - 8'h20 : a[i];
                4'd2: r[i] = (a[i] >= 8'h41 && a[i] <= 8'h5a) ? a[i] + 8'h20 : a[i];
                4'd3: r[i] = a[N-1-i];
                default: r[i] = a[i];
            endcase
        end
        if (op == 4'd0)
            r[3] = (a == b) ? 8'd1 : 8'd0;
        return r;
    endfunction

    // Accelerator stand-in: raises done lat cycles into a go pulse, drops it hold cycles after go falls.
    initial begin
        forever begin
            @(negedge clk);
            if (go && !prev_go)
                go_rises++;
            if (go) begin
                run_len++;
                if (!stall && run_len >= lat && !done) begin
                    Result   = acc_op(index, A, B);
                    done     = 1'b1;
                    hold_cnt = 0;
                end
            end else begin
                if (prev_go)
                    last_go_len = run_len;
                run_len = 0;
                if (done) begin
                    if (hold_cnt >= hold) done = 1'b0;
                    else hold_cnt++;
                end
            end
            prev_go = go;
        end
    end

    task automatic bus_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        address = AW'(addr); writedata = data; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        @(negedge clk);
        address = AW'(addr); chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        data = readdata;
    endtask

    task automatic write_str(input bit is_b, input logic [0:N-1][7:0] s);
        for (int k = 0; k < M; k++)
            bus_write((is_b ? M : 0) + k, {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]});
        if (is_b) begin
            m_b = s;
            check_val("port_B", B, m_b);
        end else begin
            m_a = s;
            check_val("port_A", A, m_a);
        end
    endtask

    task automatic check_res(input string tag);
        logic [31:0] d;
        for (int k = 0; k < M; k++) begin
            bus_read(RES + k, d);
            check_val($sformatf("%s res%0d", tag, k), d, m_res[k]);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n = 0;
        do begin
            bus_read(STAT, s);
            n++;
        end while (s[0] && n < 100);
        check_val({tag, " busy_cleared"}, {63'b0, s[0]}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input int l,
                          input int h, input bit st, input bit poke);
        logic [31:0] d;
        logic [0:N-1][7:0] r;
        int rises0;
        bit exp_to;
        lat = l; hold = h; stall = st;
        rises0 = go_rises;
        bus_write(CTRL, {27'b0, op, 1'b1});
        m_idx = op;
        check_val({tag, " go_next"}, {63'b0, go}, 64'd1);
        check_val({tag, " index"}, {60'b0, index}, {60'b0, m_idx});
        if (poke) begin
            bus_write(0, 32'hFFFF_FFFF);
            bus_write(CTRL, 32'h0000_0007);
            bus_read(CTRL, d);
            check_val({tag, " busy_ctrl"}, d, {27'b0, m_idx, 1'b0});
            check_val({tag, " busy_A"}, A, m_a);
            bus_read(STAT, d);
            check_val({tag, " busy_status"}, d, 32'h1);
        end
        wait_idle(tag);
        exp_to = st || (l > TO);
        if (!exp_to) begin
            r = acc_op(op, m_a, m_b);
            for (int k = 0; k < M; k++)
                m_res[k] = {r[4*k], r[4*k+1], r[4*k+2], r[4*k+3]};
        end
        bus_read(STAT, d);
        check_val({tag, " status"}, d, exp_to ? 32'h4 : 32'h2);
        check_res(tag);
        check_val({tag, " go_len"}, 64'(last_go_len), 64'(exp_to ? TO : l));
        repeat (3) @(negedge clk);
        check_val({tag, " go_low"}, {63'b0, go}, 64'd0);
        check_val({tag, " single_run"}, 64'(go_rises - rises0), 64'd1);
        $display("run %s op=%0d lat=%0d hold=%0d stall=%0d status=%h res0=%h res1=%h",
                 tag, op, l, h, st, d, m_res[0], m_res[M-1]);
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(97, 122));
            1: return 8'($urandom_range(65, 90));
            2: return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(48, 57));
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [0:N-1][7:0] s1, s2;
        logic [3:0] idx;
        for (int k = 0; k < M; k++) m_res[k] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst go", {63'b0, go}, 64'd0);
        check_val("rst readdata", {32'b0, readdata}, 64'd0);
        check_val("rst A", A, 64'd0);
        reset = 1'b1;
        bus_read(STAT, d);
        check_val("rst status", d, 32'h0);
        bus_read(CTRL, d);
        check_val("rst ctrl", d, 32'h0);
        check_res("rst");
        $display("reset checked");

        // Compare equal, then to-upper
        s1 = "abcdefgh";
        write_str(1'b0, s1);
        write_str(1'b1, s1);
        run_op("cmp_eq", 4'd0, 3, 0, 1'b0, 1'b0);
        run_op("upper", 4'd1, 2, 1, 1'b0, 1'b0);
        check_val("upper res0_literal", {32'b0, m_res[0]}, 64'h4142_4344);

        // Busy lockout with a stalled accelerator ending in timeout
        run_op("lockout", 4'd2, 1, 0, 1'b1, 1'b1);
        // done arriving on the last counted cycle beats the timeout
        run_op("done_at_limit", 4'd3, TO, 0, 1'b0, 1'b0);
        run_op("done_after_limit", 4'd1, TO + 1, 0, 1'b0, 1'b0);

        // Reset in the middle of a run
        stall = 1'b1;
        bus_write(CTRL, {27'b0, 4'd3, 1'b1});
        repeat (3) @(negedge clk);
        check_val("midrst go_before", {63'b0, go}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("midrst go", {63'b0, go}, 64'd0);
        check_val("midrst readdata", {32'b0, readdata}, 64'd0);
        check_val("midrst A", A, 64'd0);
        m_a = '0; m_b = '0; m_idx = '0;
        for (int k = 0; k < M; k++) m_res[k] = '0;
        bus_read(STAT, d);
        check_val("midrst status", d, 32'h0);
        bus_read(CTRL, d);
        check_val("midrst ctrl", d, 32'h0);
        check_res("midrst");
        s2 = "HeLLo_Wd";
        write_str(1'b0, s2);
        run_op("after_rst", 4'd2, 2, 2, 1'b0, 1'b0);

        // Randomized operations
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) s1[i] = rand_char();
            if ($urandom_range(0, 1) == 0) s2 = s1;
            else for (int i = 0; i < N; i++) s2[i] = rand_char();
            write_str(1'b0, s1);
            write_str(1'b1, s2);
            idx = 4'($urandom_range(0, 15));
            bus_write(CTRL, {27'b0, idx, 1'b0});
            m_idx = idx;
            bus_read(CTRL, d);
            check_val($sformatf("rnd%0d ctrl", it), d, {27'b0, m_idx, 1'b0});
            bus_read(8 + $urandom_range(0, 7), d);
            check_val($sformatf("rnd%0d unmapped", it), d, 32'h0);
            begin
                bit st;
                st = ($urandom_range(0, 7) == 0);
                run_op($sformatf("rnd%0d", it), 4'($urandom_range(0, 3)),
                       $urandom_range(1, TO + 2), $urandom_range(0, 3), st, st);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
